// File: rtl/sym_phase_search.sv
// Symbol-timing phase selector: sweeps the four matched-filter sample phases, measures squared
// slicer error per phase and locks to the minimum. Optional manual override: PHASE_OVERRIDE_EN.
`timescale 1ns/1ps
module sym_phase_search #(
  parameter int unsigned LOG2_N      = 10,
  parameter int unsigned SETTLE_SYMS = 4
) (
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               sam_clk_en,
  input  logic               sym_clk_en,
  input  logic signed [17:0] mf_in,
  input  logic signed [17:0] ref_lvl,
  input  logic               start,
`ifdef PHASE_OVERRIDE_EN
  input  logic               manual_en,
  input  logic [1:0]         manual_phase,
`endif
  output logic signed [17:0] dec_var,
  output logic [1:0]         phase_sel,
  output logic               busy,
  output logic               done,
  output logic [31:0]        err_min
);

  localparam logic [15:0] SettleLast = 16'(SETTLE_SYMS - 1);
  localparam logic [15:0] MeasLast   = 16'((32'd1 << LOG2_N) - 32'd1);

  typedef enum logic [2:0] {StIdle, StSettle, StMeasure, StCompare, StDone} state_e;

  state_e             state_q;
  logic signed [17:0] tap1_q, tap2_q, tap3_q;
  logic signed [17:0] tap_sel;
  logic [1:0]         p;
  logic [1:0]         phase_try_q;
  logic               vld0_q, vld1_q, vld2_q;
  logic signed [19:0] e_q;
  logic [21:0]        sq_q;
  logic [31:0]        acc_q, best_q;
  logic [1:0]         best_phase_q;
  logic [15:0]        cnt_q;

  logic signed [19:0] dv20, a20, two_a, three_a, level, e_d;
  logic signed [39:0] prod;
  logic               take;
  logic               unused_prod;

  always_comb begin
    p = busy ? phase_try_q : phase_sel;
`ifdef PHASE_OVERRIDE_EN
    if (manual_en) p = manual_phase;
`endif
    case (p)
      2'd0:    tap_sel = mf_in;
      2'd1:    tap_sel = tap1_q;
      2'd2:    tap_sel = tap2_q;
      default: tap_sel = tap3_q;
    endcase
  end

  // 20-bit slicer math: 3a and dec_var - level cannot wrap for a non-negative 18-bit a
  always_comb begin
    dv20    = {{2{dec_var[17]}}, dec_var};
    a20     = {{2{ref_lvl[17]}}, ref_lvl};
    two_a   = a20 <<< 1;
    three_a = a20 + two_a;
    if (dv20 >= two_a)        level = three_a;
    else if (dv20 >= 20'sd0)  level = a20;
    else if (dv20 >= -two_a)  level = -a20;
    else                      level = -three_a;
    e_d = dv20 - level;
  end

  assign prod        = e_q * e_q;
  assign unused_prod = ^{prod[39], prod[16:0]};
  assign take        = (phase_try_q == 2'd0) || (acc_q < best_q);

  // Datapath: delay line, decision register and three-stage error pipeline
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      tap1_q  <= '0;
      tap2_q  <= '0;
      tap3_q  <= '0;
      dec_var <= '0;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
      e_q     <= '0;
      sq_q    <= '0;
    end else begin
      if (sam_clk_en) begin
        tap1_q <= mf_in;
        tap2_q <= tap1_q;
        tap3_q <= tap2_q;
      end
      if (sym_clk_en) dec_var <= tap_sel;
      vld0_q <= sym_clk_en;
      vld1_q <= vld0_q;
      vld2_q <= vld1_q;
      e_q    <= e_d;
      sq_q   <= prod[38:17];
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      phase_try_q  <= '0;
      acc_q        <= '0;
      best_q       <= '0;
      best_phase_q <= '0;
      cnt_q        <= '0;
      phase_sel    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_min      <= '0;
    end else begin
      done <= 1'b0;
`ifdef PHASE_OVERRIDE_EN
      if (manual_en) begin
        state_q   <= StIdle;
        busy      <= 1'b0;
        phase_sel <= manual_phase;
      end else begin
`else
      begin
`endif
        unique case (state_q)
          StIdle: begin
            if (start) begin
              phase_try_q <= '0;
              acc_q       <= '0;
              cnt_q       <= '0;
              busy        <= 1'b1;
              state_q     <= StSettle;
            end
          end
          StSettle: begin
            if (vld2_q) begin
              if (cnt_q == SettleLast) begin
                cnt_q   <= '0;
                acc_q   <= '0;
                state_q <= StMeasure;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          StMeasure: begin
            if (vld2_q) begin
              acc_q <= acc_q + {10'd0, sq_q};
              if (cnt_q == MeasLast) begin
                cnt_q   <= '0;
                state_q <= StCompare;
              end else begin
                cnt_q <= cnt_q + 16'd1;
              end
            end
          end
          StCompare: begin
            if (take) begin
              best_q       <= acc_q;
              best_phase_q <= phase_try_q;
            end
            if (phase_try_q == 2'd3) begin
              // Results use this cycle's comparison so they are valid while done is high
              phase_sel <= take ? phase_try_q : best_phase_q;
              err_min   <= take ? acc_q : best_q;
              done      <= 1'b1;
              busy      <= 1'b0;
              state_q   <= StDone;
            end else begin
              phase_try_q <= phase_try_q + 2'd1;
              state_q     <= StSettle;
            end
          end
          StDone:  state_q <= StIdle;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: doc/sym_phase_search.md
# sym_phase_search

Automatic symbol-timing phase selector between the receive matched filter and the slicer/MER measurement chain. It replaces the manual 4-way switch selection of the matched-filter delay tap. It sweeps all four sample phases, measures the accumulated squared slicer error at each phase over a fixed symbol window, and locks the decision-variable mux to the phase with minimum error energy. Its `dec_var` output feeds the slicer, `avg_mag` and the error path directly.

## Interface
- `LOG2_N`, 10: log2 of the number of symbols accumulated per phase.
- `SETTLE_SYMS`, 4: number of symbols discarded after each phase change before accumulation starts.
- `sys_clk` input 1: the single system clock; all state is clocked on its rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `sam_clk_en` input 1: one-cycle sample strobe; shifts the delay line.
- `sym_clk_en` input 1: one-cycle symbol strobe, coincident with a `sam_clk_en` pulse.
- `mf_in` input 18 signed: matched-filter output, format 1s17.
- `ref_lvl` input 18 signed: inner 4-ASK level `a`, from `avg_mag`; non-negative.
- `start` input 1: one-cycle pulse that begins a search.
- `dec_var` output 18 signed: selected tap, registered at the symbol strobe.
- `phase_sel` output 2: locked phase.
- `busy` output 1: high while a search is in progress.
- `done` output 1: one-cycle pulse when a search completes.
- `err_min` output 32: accumulated error energy of the winning phase.

## Operation
- Delay line `tap[0]=mf_in`, `tap[1..3]`: shifts on `sam_clk_en`; `tap[k]` is `mf_in` delayed by k samples.
- On `sym_clk_en`: `dec_var <= tap[p]`. While `busy`, `p` is `phase_try`; otherwise `p` is `phase_sel`.
- Slicer on the registered `dec_var`:
  - `dec_var >= 2a` → level `3a`
  - `dec_var >= 0` → level `a`
  - `dec_var >= -2a` → level `-a`
  - otherwise → level `-3a`
  - Compute in 20-bit signed with no wrap; `e = dec_var - level`, also 20-bit.
- Square: `sq = (e*e) >> 17`, 22-bit unsigned.
- Accumulate `sq` into a 32-bit accumulator. 2^LOG2_N × 2^22 cannot overflow for LOG2_N ≤ 10.
- FSM states:
  - IDLE: on `start`, clear `phase_try` and the accumulator, raise `busy`, go to SETTLE. `start` at any other time is ignored.
  - SETTLE: count `SETTLE_SYMS` error-valid pulses, then clear the accumulator and go to MEASURE.
  - MEASURE: accumulate 2^LOG2_N error-valid pulses, then go to COMPARE.
  - COMPARE (one cycle): update `best` and `best_phase` if `phase_try==0` or `acc < best` (strict less-than, so a tie keeps the lower phase). If `phase_try==3`, go to DONE; else increment `phase_try` and go to SETTLE.
  - DONE (one cycle): `phase_sel <= best_phase`, `err_min <= best`, `done=1`, `busy=0`, go to IDLE.
- `reset_n` low at any point, including mid-search: all state and outputs clear immediately and the FSM enters IDLE.

## Timing
- Reset values: `dec_var=0`, `phase_sel=0`, `busy=0`, `done=0`, `err_min=0`. Delay line, accumulator and counters are also 0.
- `dec_var` updates on the `sys_clk` edge where `sym_clk_en=1`.
- Error pipeline, cycles after that edge:
  - +1: level and `e` registered.
  - +2: `sq` registered.
  - +3: accumulator updated; this is the "error-valid pulse".
- Requires at least 4 `sys_clk` cycles between symbol strobes. The system provides 16.
- `busy` rises the cycle after `start`.
- Search length: 4×(SETTLE_SYMS+2^LOG2_N) symbols plus fewer than 12 cycles of overhead; `done` follows the last COMPARE by 1 cycle.
- The phase switch takes effect at the next `sym_clk_en` after `phase_try` changes.

## Configuration
- `PHASE_OVERRIDE_EN` defined:
  - Adds input ports `manual_en` (1) and `manual_phase` (2).
  - While `manual_en=1`: `p = manual_phase`, `phase_sel` tracks `manual_phase` each cycle, `start` is ignored, and an in-progress search aborts to IDLE with `busy=0` and no `done` pulse.
- Undefined: these ports are absent and selection is search-only.

## Test plan
- Reset mid-MEASURE: drop `reset_n` during MEASURE → same cycle all outputs 0; after release, FSM is IDLE and `busy=0`.
- Ideal aligned data, a=0x4000, `tap[2]`: drive `mf_in` with ±0x4000/±0xC000 at phase-2 samples and 0 elsewhere; pulse `start` → `done` after the search, `phase_sel=2`, `err_min=0`.
- Tie case: `mf_in` constant 0x4000 with a=0x4000 → all phases have zero error, so `phase_sel=0`.
- Slicer boundary, a=0x4000:
  - `dec_var=0x8000` → level 0xC000, `e=-0x4000`.
  - `dec_var=0` → level 0x4000, `e=-0x4000`, `sq=0x800`.
- Full scale, a=0, `mf_in=-131072` at all phases, LOG2_N=10 → `err_min=0x0800_0000`; no overflow.
- `start` pulsed while `busy` → ignored. `done` is high for exactly one cycle. With `PHASE_OVERRIDE_EN`, `manual_en=1`, `manual_phase=3` → `phase_sel=3` next cycle and `busy=0`.
